level_measure_sequencer: RTL and testbench
==========================================

Name: level_measure_sequencer

Overview:
- Sequences one ultrasonic level-sensor measurement cycle: trigger pulse, echo-width capture and timeout.
- Uses the 1 kHz and 1 Hz single-cycle tick strobes from the clock divider as timebases.
- Launches a measurement on every PERIOD_S-th 1 Hz tick or on a manual start request.
- Its echo-width result feeds the level computation and display path.

Parameters:
- TRIG_CYCLES, 1000, trigger pulse length in clk_100MHz cycles (10 us).
- TIMEOUT_MS, 30, maximum ms from trigger end to echo fall before aborting.
- HOLDOFF_MS, 60, minimum ms idle after any measurement before the next trigger.
- PERIOD_S, 1, number of tick_1Hz strobes between automatic measurements (>=1).
- ECHO_W, 22, width of the echo cycle count.

Ports:
- clk_100MHz  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous active-low reset.
- tick_1kHz  in  1  one-cycle strobe, 1 per ms.
- tick_1Hz  in  1  one-cycle strobe, 1 per s.
- start  in  1  one-cycle manual measurement request.
- echo_in  in  1  sensor echo, asynchronous to the clock.
- trig_out  out  1  sensor trigger.
- echo_cycles  out  ECHO_W  last valid echo width, in clocks.
- valid  out  1  one-cycle pulse when echo_cycles updates.
- timeout_err  out  1  one-cycle pulse when a measurement aborts.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, state IDLE, all counters 0, pending flag 0, synchronizer flops 0. Asserting reset mid-measurement drops trig_out immediately.
- Input synchronization: echo_in passes through a 2-flop synchronizer giving echo_s. Edges are detected on echo_s against its previous value.
- Period counter: counts tick_1Hz strobes; on reaching PERIOD_S it wraps to 0 and sets pending.
- Pending flag: start also sets pending. Pending is a one-deep flag: requests collapsing in the same cycle, or arriving while busy, merge into a single request. It clears on the IDLE->TRIG transition.
- State IDLE: if pending, go to TRIG next cycle.
- State TRIG: trig_out=1 for exactly TRIG_CYCLES consecutive clocks, then go to WAIT_HIGH with the ms counter cleared.
- State WAIT_HIGH:
  - Rising edge of echo_s: go to MEASURE with the width counter set to 1.
  - An echo already high on entry is ignored until it falls and rises again.
- State MEASURE:
  - Width counter increments every clock while echo_s=1 and saturates at 2^ECHO_W-1.
  - Falling edge of echo_s: echo_cycles<=count and valid=1 for one cycle, then go to HOLDOFF.
  - valid rises on the 3rd clk_100MHz edge after echo_in falls.
  - echo_cycles equals the number of clocks echo_in was high, within ±1 for asynchronous edges.
- Timeout: in WAIT_HIGH and MEASURE, the ms counter increments on tick_1kHz. When it reaches TIMEOUT_MS: timeout_err=1 for one cycle, echo_cycles unchanged, go to HOLDOFF. The effective window is TIMEOUT_MS-1 to TIMEOUT_MS ms.
- State HOLDOFF: clear the ms counter on entry, count tick_1kHz, and go to IDLE after HOLDOFF_MS ticks.
- Simultaneous events:
  - Timeout and echo fall in the same cycle: the echo fall wins (valid, no timeout_err).
  - start and tick_1Hz in the same cycle: one measurement.
- valid and timeout_err are never high together. trig_out is high only in TRIG.

Test Plan:
- Reset, then start pulse, echo_in high 58000 clocks starting 200 us after trigger -> trig_out high exactly 1000 clocks; valid one pulse; echo_cycles=58000±1; busy high until HOLDOFF ends 60 ms later.
- Start with echo_in held low -> timeout_err one pulse 29–30 ms after trig_out falls; valid never asserts; echo_cycles keeps its previous value.
- PERIOD_S=3, 7 tick_1Hz strobes with echo 1000 clocks each -> exactly 2 triggers, at the 3rd and 6th ticks.
- start pulsed 3 times during a busy measurement -> exactly one further measurement after holdoff.
- echo_in high before and through trigger end, then low, then high 500 clocks -> first high ignored; echo_cycles=500±1.
- reset_n asserted in the middle of TRIG and again in the middle of MEASURE -> trig_out=0 and busy=0 immediately, no valid; a fresh start afterwards produces a full, correct measurement.

Source files
------------

// File: rtl/level_measure_sequencer.sv
// Ultrasonic level-sensor measurement sequencer: trigger pulse, echo-width capture, timeout
// and post-measurement holdoff, paced by external 1 kHz / 1 Hz tick strobes.
module level_measure_sequencer #(
  parameter int unsigned TRIG_CYCLES = 1000,
  parameter int unsigned TIMEOUT_MS  = 30,
  parameter int unsigned HOLDOFF_MS  = 60,
  parameter int unsigned PERIOD_S    = 1,
  parameter int unsigned ECHO_W      = 22
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              tick_1kHz,
  input  logic              tick_1Hz,
  input  logic              start,
  input  logic              echo_in,
  output logic              trig_out,
  output logic [ECHO_W-1:0] echo_cycles,
  output logic              valid,
  output logic              timeout_err,
  output logic              busy
);

  localparam int unsigned TrigW = $clog2(TRIG_CYCLES + 1);
  localparam int unsigned MsMax = (TIMEOUT_MS > HOLDOFF_MS) ? TIMEOUT_MS : HOLDOFF_MS;
  localparam int unsigned MsW   = $clog2(MsMax + 1);
  localparam int unsigned PerW  = $clog2(PERIOD_S + 1);

  typedef enum logic [2:0] {StIdle, StTrig, StWaitHigh, StMeasure, StHoldoff} state_e;

  state_e              state_q, state_d;
  logic                echo_meta_q, echo_s_q, echo_prev_q;
  logic [TrigW-1:0]    trig_cnt_q, trig_cnt_d;
  logic [MsW-1:0]      ms_q, ms_d;
  logic [ECHO_W-1:0]   width_q, width_d;
  logic [ECHO_W-1:0]   echo_cycles_q, echo_cycles_d;
  logic [PerW-1:0]     per_q, per_d;
  logic                pending_q, pending_d;
  logic                valid_q, valid_d;
  logic                timeout_err_q, timeout_err_d;
  logic                trig_q, busy_q;
  logic                echo_rise, echo_fall, period_wrap, ms_timeout, launch;

  assign echo_rise   = echo_s_q & ~echo_prev_q;
  assign echo_fall   = ~echo_s_q & echo_prev_q;
  assign period_wrap = tick_1Hz && (per_q == PerW'(PERIOD_S - 1));
  assign ms_timeout  = tick_1kHz && (ms_q == MsW'(TIMEOUT_MS - 1));

  always_comb begin
    per_d = per_q;
    if (tick_1Hz) begin
      per_d = period_wrap ? '0 : per_q + PerW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    trig_cnt_d    = trig_cnt_q;
    ms_d          = ms_q;
    width_d       = width_q;
    echo_cycles_d = echo_cycles_q;
    valid_d       = 1'b0;
    timeout_err_d = 1'b0;
    launch        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          state_d    = StTrig;
          trig_cnt_d = '0;
          launch     = 1'b1;
        end
      end
      StTrig: begin
        if (trig_cnt_q == TrigW'(TRIG_CYCLES - 1)) begin
          state_d = StWaitHigh;
          ms_d    = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + TrigW'(1);
        end
      end
      StWaitHigh: begin
        if (ms_timeout) begin
          timeout_err_d = 1'b1;
          state_d       = StHoldoff;
          ms_d          = '0;
        end else begin
          if (tick_1kHz) ms_d = ms_q + MsW'(1);
          // Only a fresh rise counts; an echo already high on entry must fall first.
          if (echo_rise) begin
            state_d = StMeasure;
            width_d = ECHO_W'(1);
          end
        end
      end
      StMeasure: begin
        // Echo fall takes priority over a coincident timeout.
        if (echo_fall) begin
          echo_cycles_d = width_q;
          valid_d       = 1'b1;
          state_d       = StHoldoff;
          ms_d          = '0;
        end else if (ms_timeout) begin
          timeout_err_d = 1'b1;
          state_d       = StHoldoff;
          ms_d          = '0;
        end else begin
          if (tick_1kHz) ms_d = ms_q + MsW'(1);
          if (echo_s_q && !(&width_q)) width_d = width_q + ECHO_W'(1);
        end
      end
      StHoldoff: begin
        if (tick_1kHz) begin
          if (ms_q == MsW'(HOLDOFF_MS - 1)) begin
            state_d = StIdle;
            ms_d    = '0;
          end else begin
            ms_d = ms_q + MsW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A request arriving in the launch cycle itself is kept as a new request.
  assign pending_d = (pending_q & ~launch) | start | period_wrap;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      echo_meta_q   <= 1'b0;
      echo_s_q      <= 1'b0;
      echo_prev_q   <= 1'b0;
      trig_cnt_q    <= '0;
      ms_q          <= '0;
      width_q       <= '0;
      echo_cycles_q <= '0;
      per_q         <= '0;
      pending_q     <= 1'b0;
      valid_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      trig_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      echo_meta_q   <= echo_in;
      echo_s_q      <= echo_meta_q;
      echo_prev_q   <= echo_s_q;
      trig_cnt_q    <= trig_cnt_d;
      ms_q          <= ms_d;
      width_q       <= width_d;
      echo_cycles_q <= echo_cycles_d;
      per_q         <= per_d;
      pending_q     <= pending_d;
      valid_q       <= valid_d;
      timeout_err_q <= timeout_err_d;
      trig_q        <= (state_d == StTrig);
      busy_q        <= (state_d != StIdle);
    end
  end

  assign trig_out    = trig_q;
  assign echo_cycles = echo_cycles_q;
  assign valid       = valid_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_level_measure_sequencer.sv
// Scoreboard bench for level_measure_sequencer with scaled-down timebases and random echo widths.
module tb_level_measure_sequencer;

  localparam int TRIG  = 20;
  localparam int TO_MS = 6;
  localparam int HO_MS = 4;
  localparam int PER   = 3;
  localparam int EW    = 8;
  localparam int MS_P  = 100;
  localparam int SAT   = (1 << EW) - 1;
  localparam int SEL_TRIG = 0;
  localparam int SEL_BUSY = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick_1kHz = 1'b0;
  logic          tick_1Hz = 1'b0;
  logic          start = 1'b0;
  logic          echo_in = 1'b0;
  logic          trig_out, valid, timeout_err, busy;
  logic [EW-1:0] echo_cycles;

  level_measure_sequencer #(
    .TRIG_CYCLES(TRIG),
    .TIMEOUT_MS (TO_MS),
    .HOLDOFF_MS (HO_MS),
    .PERIOD_S   (PER),
    .ECHO_W     (EW)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .tick_1kHz  (tick_1kHz),
    .tick_1Hz   (tick_1Hz),
    .start      (start),
    .echo_in    (echo_in),
    .trig_out   (trig_out),
    .echo_cycles(echo_cycles),
    .valid      (valid),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_to;
    int width;
    int fall_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_good = 0;
  int   trig_count = 0;
  int   trig_rise_cyc = 0;
  int   trig_fall_cyc = 0;
  logic trig_prev = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Free-running 1 ms strobe, scaled to MS_P clocks.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      k = (k + 1) % MS_P;
      tick_1kHz = (k == 0);
    end
  end

  // Trigger monitor: pulse length and count.
  initial begin
    forever begin
      @(negedge clk);
      if (trig_out && !trig_prev) trig_rise_cyc = cyc;
      if (!trig_out && trig_prev) begin
        trig_fall_cyc = cyc;
        if (reset_n) begin
          trig_count++;
          chk(cyc - trig_rise_cyc == TRIG, "trig_len", cyc - trig_rise_cyc, TRIG);
        end
      end
      trig_prev = trig_out;
    end
  end

  // Result monitor: pops the scoreboard on every valid / timeout_err.
  initial begin
    forever begin
      @(negedge clk);
      if (valid || timeout_err) begin
        chk(!(valid && timeout_err), "valid_timeout_exclusive", {valid, timeout_err}, 0);
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_result", {valid, timeout_err}, 0);
        end else begin
          mon_e = sb.pop_front();
          if (!mon_e.is_to) begin
            chk(valid, "result_is_valid", valid, 1);
            chk(int'(echo_cycles) >= mon_e.width - 1 && int'(echo_cycles) <= mon_e.width + 1,
                "echo_cycles", echo_cycles, mon_e.width);
            chk(cyc - mon_e.fall_cyc == 3, "valid_latency", cyc - mon_e.fall_cyc, 3);
            last_good = mon_e.width;
          end else begin
            chk(timeout_err, "result_is_timeout", timeout_err, 1);
            chk(int'(echo_cycles) >= last_good - 1 && int'(echo_cycles) <= last_good + 1,
                "echo_cycles_held", echo_cycles, last_good);
            chk(cyc - trig_fall_cyc >= (TO_MS - 1) * MS_P && cyc - trig_fall_cyc <= TO_MS * MS_P + 2,
                "timeout_window", cyc - trig_fall_cyc, TO_MS * MS_P);
          end
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d, expected completion earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cond(input int sel, input logic lvl, input int budget, input string name,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (((sel == SEL_TRIG) ? trig_out : busy) == lvl) begin
        ok = 1'b1;
        break;
      end
    end
    chk(ok, name, ok, 1);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_tick();
    @(posedge clk);
    #1 tick_1Hz = 1'b1;
    @(posedge clk);
    #1 tick_1Hz = 1'b0;
  endtask

  // Echo high for exactly n clocks after a delay; expectation is pushed at the falling edge.
  task automatic drive_echo(input int delay, input int n);
    exp_t e;
    repeat (delay) @(posedge clk);
    #1 echo_in = 1'b1;
    repeat (n) @(posedge clk);
    #1 echo_in = 1'b0;
    e.is_to    = 1'b0;
    e.width    = (n > SAT) ? SAT : n;
    e.fall_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic measure(input bit do_start, input bit to, input int delay, input int n);
    bit   ok;
    int   t0;
    exp_t e;
    if (do_start) begin
      wait_cond(SEL_BUSY, 1'b0, 2000, "idle_before_start", ok);
      pulse_start();
    end
    wait_cond(SEL_TRIG, 1'b1, 1500, "trig_rise", ok);
    if (!ok) return;
    wait_cond(SEL_TRIG, 1'b0, TRIG + 5, "trig_fall", ok);
    if (!ok) return;
    if (to) begin
      e.is_to = 1'b1;
      e.width = 0;
      e.fall_cyc = 0;
      sb.push_back(e);
      t0 = cyc + (TO_MS - 1) * MS_P;
    end else begin
      drive_echo(delay, n);
      t0 = cyc;
    end
    wait_cond(SEL_BUSY, 1'b0, (TO_MS + HO_MS + 2) * MS_P + n, "busy_end", ok);
    chk(cyc - t0 >= (HO_MS - 1) * MS_P, "holdoff_len", cyc - t0, HO_MS * MS_P);
  endtask

  initial begin
    bit ok;
    int tc0;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk(trig_out == 1'b0, "reset_trig", trig_out, 0);
    chk(busy == 1'b0, "reset_busy", busy, 0);
    chk(valid == 1'b0, "reset_valid", valid, 0);
    chk(timeout_err == 1'b0, "reset_timeout", timeout_err, 0);
    chk(echo_cycles == '0, "reset_echo_cycles", echo_cycles, 0);
    reset_n = 1'b1;

    // Basic measurements, one saturating.
    measure(1'b1, 1'b0, 15, 300);
    measure(1'b1, 1'b0, 20, 120);

    // Echo already high through trigger end must be ignored.
    echo_in = 1'b1;
    pulse_start();
    wait_cond(SEL_TRIG, 1'b1, 50, "pre_trig_rise", ok);
    wait_cond(SEL_TRIG, 1'b0, TRIG + 5, "pre_trig_fall", ok);
    repeat (20) @(posedge clk);
    #1 echo_in = 1'b0;
    drive_echo(15, 50);
    wait_cond(SEL_BUSY, 1'b0, (TO_MS + HO_MS + 2) * MS_P, "pre_busy_end", ok);

    // Echo held low: timeout.
    measure(1'b1, 1'b1, 0, 0);

    // Starts during a busy measurement merge into one follow-up measurement.
    tc0 = trig_count;
    pulse_start();
    wait_cond(SEL_TRIG, 1'b1, 50, "merge_trig_rise", ok);
    wait_cond(SEL_TRIG, 1'b0, TRIG + 5, "merge_trig_fall", ok);
    drive_echo(10, 80);
    repeat (3) begin
      repeat (7) @(posedge clk);
      pulse_start();
    end
    wait_cond(SEL_BUSY, 1'b0, (TO_MS + HO_MS + 2) * MS_P, "merge_busy_end", ok);
    measure(1'b0, 1'b1, 0, 0);
    repeat ((TO_MS + HO_MS + 2) * MS_P) @(posedge clk);
    chk(trig_count - tc0 == 2, "merge_trig_count", trig_count - tc0, 2);

    // Random echo widths.
    for (int i = 0; i < 5; i++) begin
      n = int'($urandom_range(3, 400));
      measure(1'b1, 1'b0, int'($urandom_range(5, 40)), n);
    end

    // Automatic measurements every PER-th tick_1Hz.
    tc0 = trig_count;
    for (int k = 1; k <= 7; k++) begin
      pulse_tick();
      if (k % PER == 0) begin
        measure(1'b0, 1'b0, int'($urandom_range(5, 30)), int'($urandom_range(20, 250)));
      end else begin
        repeat (60) @(posedge clk);
        chk(trig_count == tc0 + k / PER, "period_no_trig", trig_count - tc0, k / PER);
      end
    end
    chk(trig_count - tc0 == 7 / PER, "period_trig_count", trig_count - tc0, 7 / PER);

    // 8th tick alone, then 9th tick together with start: one measurement.
    pulse_tick();
    repeat (60) @(posedge clk);
    chk(trig_count - tc0 == 2, "tick8_no_trig", trig_count - tc0, 2);
    @(posedge clk);
    #1 tick_1Hz = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 tick_1Hz = 1'b0;
    start = 1'b0;
    measure(1'b0, 1'b0, 12, 90);
    repeat ((HO_MS + 2) * MS_P) @(posedge clk);
    chk(trig_count - tc0 == 3, "combo_trig_count", trig_count - tc0, 3);

    // Reset in the middle of TRIG.
    pulse_start();
    wait_cond(SEL_TRIG, 1'b1, 50, "rst1_trig_rise", ok);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk(trig_out == 1'b0, "rst_trig_trig_out", trig_out, 0);
    chk(busy == 1'b0, "rst_trig_busy", busy, 0);
    last_good = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset in the middle of MEASURE.
    pulse_start();
    wait_cond(SEL_TRIG, 1'b0, 60, "rst2_trig_done", ok);
    repeat (10) @(posedge clk);
    #1 echo_in = 1'b1;
    repeat (50) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk(trig_out == 1'b0, "rst_meas_trig_out", trig_out, 0);
    chk(busy == 1'b0, "rst_meas_busy", busy, 0);
    chk(valid == 1'b0, "rst_meas_valid", valid, 0);
    echo_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (50) @(posedge clk);
    measure(1'b1, 1'b0, 12, 200);

    repeat (10) @(posedge clk);
    chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
